// File: rtl/sha256_stream_processor.sv
// sha256_stream_processor: byte-stream SHA-256/224 front end with padding and block chaining
// around an iterative one-round-per-cycle compression core.
module sha256_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block,
    input  logic [255:0] hash_init,
    input  logic         use_init,
    output logic         ready,
    output logic [255:0] hash_out
);
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    typedef struct packed {
        logic              run;
        logic [5:0]        rnd;
        logic [0:7][31:0]  v;
        logic [0:7][31:0]  init;
        logic [0:15][31:0] w;
        logic [0:7][31:0]  hash;
    } core_t;
    core_t r_q, r_d;
    logic [31:0] t1, t2, w_new;
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    assign ready    = !r_q.run;
    assign hash_out = r_q.hash;
    always_comb begin
        r_d   = r_q;
        t1    = r_q.v[7] + (rotr(r_q.v[4], 6) ^ rotr(r_q.v[4], 11) ^ rotr(r_q.v[4], 25))
              + ((r_q.v[4] & r_q.v[5]) ^ (~r_q.v[4] & r_q.v[6])) + K[r_q.rnd] + r_q.w[0];
        t2    = (rotr(r_q.v[0], 2) ^ rotr(r_q.v[0], 13) ^ rotr(r_q.v[0], 22))
              + ((r_q.v[0] & r_q.v[1]) ^ (r_q.v[0] & r_q.v[2]) ^ (r_q.v[1] & r_q.v[2]));
        // w is a 16-word window: w[0] is the schedule word for the current round
        w_new = (rotr(r_q.w[14], 17) ^ rotr(r_q.w[14], 19) ^ (r_q.w[14] >> 10)) + r_q.w[9]
              + (rotr(r_q.w[1], 7) ^ rotr(r_q.w[1], 18) ^ (r_q.w[1] >> 3)) + r_q.w[0];
        if (!r_q.run) begin
            if (start) begin
                r_d.run  = 1'b1;
                r_d.rnd  = '0;
                r_d.init = use_init ? hash_init : IV;
                r_d.v    = r_d.init;
                r_d.w    = block;
            end
        end else begin
            r_d.v   = {t1 + t2, r_q.v[0:2], r_q.v[3] + t1, r_q.v[4:6]};
            r_d.w   = {r_q.w[1:15], w_new};
            r_d.rnd = r_q.rnd + 6'd1;
            if (r_q.rnd == 6'd63) begin
                r_d.run = 1'b0;
                for (int i = 0; i < 8; i++) r_d.hash[i] = r_q.init[i] + r_d.v[i];
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '0;
        else     r_q <= r_d;
endmodule

module sha256_stream_processor #(
    parameter int IN_BYTES    = 4,
    parameter bit SUPPORT_224 = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            mode_224,
    input  logic                            abort,
    input  logic [IN_BYTES*8-1:0]           s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    input  logic [$clog2(IN_BYTES+1)-1:0]   s_keep,
    output logic                            s_ready,
    output logic [255:0]                    hash_out,
    output logic                            hash_valid,
    output logic                            busy
);
    localparam int KW = $clog2(IN_BYTES + 1);
    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    typedef enum logic [2:0] {IDLE, LOAD, PAD, HASH, DONE} state_t;
    typedef struct packed {
        state_t       state;
        logic [511:0] blk;
        logic [6:0]   idx;
        logic [63:0]  bit_len;
        logic [255:0] chain;
        logic [255:0] hash;
        logic         hash_valid;
        logic         m224;
        logic         tail;
        logic         need_len;
        logic         fin;
        logic         issued;
        logic         rdy_prev;
    } regs_t;
    regs_t r_q, r_d;
    logic          core_start, core_ready;
    logic [255:0]  core_hash;
    logic [KW-1:0] keep_c;
    logic [6:0]    nb;
    assign keep_c     = (s_keep > KW'(IN_BYTES)) ? KW'(IN_BYTES) : s_keep;
    assign nb         = s_last ? 7'(keep_c) : 7'(IN_BYTES);
    assign s_ready    = (r_q.state == LOAD) && (r_q.idx < 7'd64);
    assign busy       = r_q.state inside {LOAD, PAD, HASH};
    assign hash_out   = r_q.hash;
    assign hash_valid = r_q.hash_valid;
    always_comb begin
        r_d          = r_q;
        r_d.rdy_prev = core_ready;
        core_start   = 1'b0;
        if (abort) begin
            r_d.state      = IDLE;
            r_d.hash_valid = 1'b0;
        end else if (start && (r_q.state == IDLE || r_q.state == DONE)) begin
            r_d.state      = LOAD;
            r_d.idx        = '0;
            r_d.bit_len    = '0;
            r_d.hash_valid = 1'b0;
            r_d.tail       = 1'b0;
            r_d.need_len   = 1'b0;
            r_d.fin        = 1'b0;
            r_d.m224       = SUPPORT_224 && mode_224;
            r_d.chain      = r_d.m224 ? IV224 : IV256;
        end else begin
            case (r_q.state)
                LOAD: if (s_valid && s_ready) begin
                    for (int j = 0; j < IN_BYTES; j++)
                        if (7'(j) < nb) r_d.blk[511 - 8 * (int'(r_q.idx) + j) -: 8] = s_data[IN_BYTES*8 - 1 - 8*j -: 8];
                    r_d.idx     = r_q.idx + nb;
                    r_d.bit_len = r_q.bit_len + (64'(nb) << 3);
                    r_d.tail    = s_last;
                    r_d.issued  = 1'b0;
                    r_d.state   = (r_d.idx == 7'd64) ? HASH : s_last ? PAD : LOAD;
                end
                PAD: begin
                    for (int k = 0; k < 64; k++)
                        if (r_q.need_len || k > int'(r_q.idx)) r_d.blk[511 - 8*k -: 8] = 8'h00;
                        else if (k == int'(r_q.idx)) r_d.blk[511 - 8*k -: 8] = 8'h80;
                    r_d.fin      = r_q.need_len || r_q.idx <= 7'd55;
                    r_d.need_len = !r_d.fin;
                    if (r_d.fin) r_d.blk[63:0] = r_q.bit_len;
                    r_d.issued   = 1'b0;
                    r_d.state    = HASH;
                end
                // issue only once the core is idle: an aborted run may still be finishing
                HASH: if (!r_q.issued) begin
                    core_start = core_ready;
                    r_d.issued = core_ready;
                end else if (core_ready && !r_q.rdy_prev) begin
                    r_d.chain = core_hash;
                    r_d.idx   = '0;
                    r_d.state = r_q.fin ? DONE : r_q.tail ? PAD : LOAD;
                    if (r_q.fin) begin
                        r_d.hash       = r_q.m224 ? {core_hash[255:32], 32'h0} : core_hash;
                        r_d.hash_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '0;
        else     r_q <= r_d;
    sha256_core u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .block     (r_q.blk),
        .hash_init (r_q.chain),
        .use_init  (1'b1),
        .ready     (core_ready),
        .hash_out  (core_hash)
    );
endmodule
